// File: rtl/compress_sched_pkg.sv
// Shared constants, state encoding and helpers for the compression-round scheduler.
package compress_sched_pkg;

    localparam int ROUNDS          = 10;
    localparam int G_STEPS         = 8;
    localparam int BLOCK_BYTES     = 64;
    localparam int DIGEST_MAX      = 32;
    localparam int KEY_BLOCK_BYTES = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD     = 3'd1;
    localparam state_t ST_INIT     = 3'd2;
    localparam state_t ST_COMPRESS = 3'd3;
    localparam state_t ST_FINAL    = 3'd4;
    localparam state_t ST_OUTPUT   = 3'd5;

    // Zero or oversized digest requests fall back to the full digest width.
    function automatic logic [5:0] digest_len(input logic [5:0] nn);
        if (nn == 6'd0 || int'(nn) > DIGEST_MAX) return 6'(DIGEST_MAX);
        return nn;
    endfunction

endpackage

// File: rtl/compress_sched_round_cnt.sv
// G-step / round counter for one compression; wraps to zero after the last step.
module sched_round_cnt
    import compress_sched_pkg::*;
#(
    parameter int ROUNDS  = compress_sched_pkg::ROUNDS,
    parameter int G_STEPS = compress_sched_pkg::G_STEPS
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       en,
    output logic [3:0] round,
    output logic [2:0] g_idx,
    output logic       done
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [2:0] LAST_G     = 3'(G_STEPS - 1);

    assign done = en && (round == LAST_ROUND) && (g_idx == LAST_G);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            round <= 4'd0;
            g_idx <= 3'd0;
        end else if (en) begin
            if (g_idx == LAST_G) begin
                g_idx <= 3'd0;
                round <= (round == LAST_ROUND) ? 4'd0 : round + 4'd1;
            end else begin
                g_idx <= g_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/compress_sched.sv
// Block scheduler: collects a message block, then sequences init, G steps, finalisation and digest output.
module compress_sched
    import compress_sched_pkg::*;
#(
    parameter int ROUNDS      = compress_sched_pkg::ROUNDS,
    parameter int G_STEPS     = compress_sched_pkg::G_STEPS,
    parameter int BLOCK_BYTES = compress_sched_pkg::BLOCK_BYTES
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        data_v_i,
    input  logic [5:0]  data_idx_i,
    input  logic        block_first_i,
    input  logic        block_last_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    output logic        init_o,
    output logic        g_v_o,
    output logic [3:0]  round_o,
    output logic [2:0]  g_idx_o,
    output logic [63:0] t_o,
    output logic        f_o,
    output logic        fin_o,
    output logic        hash_v_o,
    output logic [4:0]  hash_idx_o,
    output logic        busy_o,
    output logic        err_o,
    output state_t      state_o
);

    state_t      state, state_nx;
    logic        first_q, last_q;
    logic [63:0] t_q;
    logic        f_q;
    logic [5:0]  out_n;
    logic [4:0]  out_cnt;
    logic        err_q;

    logic [3:0]  cnt_round;
    logic [2:0]  cnt_g;
    logic        cnt_done;

    logic        byte_last;
    logic        busy;
    logic        enter_compress;
    logic        last_now;
    logic [63:0] t_base;
    logic [63:0] t_entry;

    sched_round_cnt #(
        .ROUNDS  (ROUNDS),
        .G_STEPS (G_STEPS)
    ) u_round_cnt (
        .clk    (clk),
        .nreset (nreset),
        .en     (state == ST_COMPRESS),
        .round  (cnt_round),
        .g_idx  (cnt_g),
        .done   (cnt_done)
    );

    assign byte_last = data_v_i && (data_idx_i == 6'(BLOCK_BYTES - 1));
    assign busy      = !(state == ST_IDLE || state == ST_LOAD);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (data_v_i) state_nx = ST_LOAD;
            ST_LOAD:     if (byte_last) state_nx = block_first_i ? ST_INIT : ST_COMPRESS;
            ST_INIT:     state_nx = ST_COMPRESS;
            ST_COMPRESS: if (cnt_done) state_nx = ST_FINAL;
            ST_FINAL:    state_nx = last_q ? ST_OUTPUT : ST_IDLE;
            ST_OUTPUT:   if ({1'b0, out_cnt} == out_n - 6'd1) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // A block going straight from LOAD to COMPRESS has not latched its flags yet.
    assign enter_compress = (state_nx == ST_COMPRESS) && (state != ST_COMPRESS);
    assign last_now       = (state == ST_LOAD) ? block_last_i : last_q;
    assign t_base         = (state == ST_INIT && first_q) ? 64'd0 : t_q;
    assign t_entry        = last_now
                          ? ll_i + ((kk_i != 6'd0) ? 64'(KEY_BLOCK_BYTES) : 64'd0)
                          : t_base + 64'(BLOCK_BYTES);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= ST_IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            t_q     <= 64'd0;
            f_q     <= 1'b0;
            out_n   <= 6'd0;
            out_cnt <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == ST_LOAD && byte_last) begin
                first_q <= block_first_i;
                last_q  <= block_last_i;
                if (block_first_i) t_q <= 64'd0;
            end

            if (enter_compress) begin
                t_q <= t_entry;
                f_q <= last_now;
            end else if (state == ST_FINAL) begin
                f_q <= 1'b0;
            end

            if (state == ST_FINAL) begin
                out_cnt <= 5'd0;
                out_n   <= digest_len(nn_i);
            end else if (state == ST_OUTPUT) begin
                out_cnt <= out_cnt + 5'd1;
            end

            // A stray byte outranks the clear from a new message start.
            if (data_v_i && busy) begin
                err_q <= 1'b1;
            end else if (state == ST_LOAD && byte_last && block_first_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign init_o     = (state == ST_INIT);
    assign g_v_o      = (state == ST_COMPRESS);
    assign round_o    = (state == ST_COMPRESS) ? cnt_round : 4'd0;
    assign g_idx_o    = (state == ST_COMPRESS) ? cnt_g : 3'd0;
    assign t_o        = t_q;
    assign f_o        = f_q;
    assign fin_o      = (state == ST_FINAL);
    assign hash_v_o   = (state == ST_OUTPUT);
    assign hash_idx_o = (state == ST_OUTPUT) ? out_cnt : 5'd0;
    assign busy_o     = busy;
    assign err_o      = err_q;
    assign state_o    = state;

endmodule

// File: tb/tb_compress_sched.sv
// Randomized scoreboard bench for compress_sched: a message-level model predicts every strobe beat.
module tb_compress_sched;
    import compress_sched_pkg::*;

    localparam int W = 81;

    logic        clk;
    logic        nreset;
    logic        data_v_i;
    logic [5:0]  data_idx_i;
    logic        block_first_i;
    logic        block_last_i;
    logic [5:0]  kk_i;
    logic [5:0]  nn_i;
    logic [63:0] ll_i;
    logic        init_o;
    logic        g_v_o;
    logic [3:0]  round_o;
    logic [2:0]  g_idx_o;
    logic [63:0] t_o;
    logic        f_o;
    logic        fin_o;
    logic        hash_v_o;
    logic [4:0]  hash_idx_o;
    logic        busy_o;
    logic        err_o;
    state_t      state_o;

    compress_sched dut (
        .clk           (clk),
        .nreset        (nreset),
        .data_v_i      (data_v_i),
        .data_idx_i    (data_idx_i),
        .block_first_i (block_first_i),
        .block_last_i  (block_last_i),
        .kk_i          (kk_i),
        .nn_i          (nn_i),
        .ll_i          (ll_i),
        .init_o        (init_o),
        .g_v_o         (g_v_o),
        .round_o       (round_o),
        .g_idx_o       (g_idx_o),
        .t_o           (t_o),
        .f_o           (f_o),
        .fin_o         (fin_o),
        .hash_v_o      (hash_v_o),
        .hash_idx_o    (hash_idx_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .state_o       (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [63:0] m_t;

    function automatic logic [W-1:0] pack(input logic i, input logic g, input logic fn,
                                          input logic h, input logic [3:0] r,
                                          input logic [2:0] gi, input logic [63:0] t,
                                          input logic f, input logic [4:0] hi);
        return {i, g, fn, h, r, gi, t, f, hi};
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe beat must match the next predicted beat.
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (nreset && (init_o || g_v_o || fin_o || hash_v_o)) begin
            act = pack(init_o, g_v_o, fin_o, hash_v_o,
                       hash_v_o ? 4'd0 : round_o, hash_v_o ? 3'd0 : g_idx_o,
                       hash_v_o ? 64'd0 : t_o, hash_v_o ? 1'b0 : f_o, hash_idx_o);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL beat: got %h expected %h", act, exp);
                end
            end
        end
    end

    // Reference model: what one block of a message should produce, straight from the block rules.
    task automatic model_block(input bit first, input bit last, input logic [5:0] kk,
                               input logic [63:0] ll, input logic [5:0] nn);
        int n;
        if (first) begin
            m_t = 64'd0;
            exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 64'd0, 1'b0, 5'd0));
        end
        if (last) m_t = ll + ((kk != 0) ? 64'd64 : 64'd0);
        else      m_t = m_t + 64'd64;
        for (int i = 0; i < ROUNDS * G_STEPS; i++)
            exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 4'(i / G_STEPS), 3'(i % G_STEPS),
                                 m_t, last, 5'd0));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, m_t, last, 5'd0));
        if (last) begin
            n = (nn == 0 || nn > 32) ? 32 : int'(nn);
            for (int j = 0; j < n; j++)
                exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 64'd0, 1'b0, 5'(j)));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input bit first, input bit last);
        for (int idx = 0; idx < BLOCK_BYTES; idx++) begin
            data_v_i = 1'b0;
            repeat ($urandom_range(0, 1)) tick();
            data_v_i      = 1'b1;
            data_idx_i    = 6'(idx);
            block_first_i = first;
            block_last_i  = last;
            tick();
        end
        data_v_i = 1'b0;
        if (first) begin
            @(negedge clk);
            check_val("init_timing", 64'(init_o), 64'd1);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            if (!busy_o) break;
            tick();
        end
        if (k == 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic run_msg(input int nblk, input logic [5:0] kk, input logic [63:0] ll,
                           input logic [5:0] nn);
        kk_i = kk;
        ll_i = ll;
        nn_i = nn;
        for (int b = 0; b < nblk; b++) begin
            model_block(b == 0, b == nblk - 1, kk, ll, nn);
            send_block(b == 0, b == nblk - 1);
            wait_idle();
        end
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] out_vec();
        return {init_o, g_v_o, round_o, g_idx_o, f_o, fin_o, hash_v_o, hash_idx_o,
                busy_o, err_o, 1'b0, t_o[31:0] | t_o[63:32]} & 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int k;
        nreset        = 1'b0;
        data_v_i      = 1'b0;
        data_idx_i    = 6'd0;
        block_first_i = 1'b0;
        block_last_i  = 1'b0;
        kk_i          = 6'd0;
        nn_i          = 6'd0;
        ll_i          = 64'd0;
        #2;
        check_val("reset_outputs", out_vec(), 64'd0);
        check_val("reset_t", t_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        tick();

        run_msg(1, 6'd0, 64'd3, 6'd32);
        run_msg(3, 6'd0, 64'd150, 6'd32);
        run_msg(2, 6'd16, 64'd10, 6'd32);
        run_msg(1, 6'd0, 64'd7, 6'd0);
        run_msg(1, 6'd0, 64'd7, 6'd40);
        run_msg(1, 6'd0, 64'd7, 6'd20);
        run_msg(2, 6'd5, 64'hFFFF_FFFF_FFFF_FFE0, 6'd1);
        for (int r = 0; r < 4; r++)
            run_msg($urandom_range(1, 3), 6'($urandom_range(0, 63)),
                    {$urandom, $urandom}, 6'($urandom_range(0, 63)));

        // Stray byte mid-compression: flagged, schedule undisturbed.
        kk_i = 6'd0; ll_i = 64'd100; nn_i = 6'd4;
        model_block(1, 0, 6'd0, 64'd100, 6'd4);
        send_block(1, 0);
        for (k = 0; k < 300; k++) begin
            if (g_v_o && round_o == 4'd2) break;
            tick();
        end
        check_val("err_wait_round2", 64'(k < 300), 64'd1);
        data_v_i   = 1'b1;
        data_idx_i = 6'($urandom_range(0, 63));
        tick();
        data_v_i = 1'b0;
        check_val("err_set", 64'(err_o), 64'd1);
        wait_idle();
        check_val("err_sticky", 64'(err_o), 64'd1);
        model_block(0, 1, 6'd0, 64'd100, 6'd4);
        send_block(0, 1);
        wait_idle();
        check_val("err_hold_nonfirst", 64'(err_o), 64'd1);
        check_val("queue_err_msg", 64'(exp_q.size()), 64'd0);
        ll_i = 64'd9;
        model_block(1, 1, 6'd0, 64'd9, 6'd4);
        send_block(1, 1);
        check_val("err_clear", 64'(err_o), 64'd0);
        wait_idle();
        check_val("queue_err_clear", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of round 5.
        kk_i = 6'd0; ll_i = 64'd500; nn_i = 6'd8;
        model_block(1, 1, 6'd0, 64'd500, 6'd8);
        send_block(1, 1);
        for (k = 0; k < 300; k++) begin
            if (g_v_o && round_o == 4'd5) break;
            tick();
        end
        check_val("rst_wait_round5", 64'(k < 300), 64'd1);
        #2 nreset = 1'b0;
        #1;
        check_val("async_reset_outputs", out_vec(), 64'd0);
        check_val("async_reset_t", t_o, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        tick();
        run_msg(1, 6'd0, 64'd3, 6'd32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
